// File: rtl/branch_target_unit.sv
// -----------------------------------------------------------------------------
// branch_target_unit
//
// Instruction address offset queue (front/back) with delayed-branch handling.
// Each unstalled clock edge ("advance") moves the queue one instruction forward.
// An accepted taken branch puts its delay slot at the front and the branch
// target at the back. The unit also produces the nullification flag for the
// next instruction, the branch-and-link return address and a saturating count
// of taken branches. Every output comes straight from a flop.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   stall        holds the queue and status flags while high
//   redirect     load redirect_pc into the queue; wins over stall and branches
//   redirect_pc  redirect target address
//   br_valid     instruction at pc_front is a branch
//   offset_in    sign-extended word offset of the branch
//   cond_eval    branch condition true (taken)
//   bl           branch-and-link
//   n_bit        nullify bit of the branch
//   pc_front     queue front (address of the current instruction)
//   pc_back      queue back (address of the next instruction)
//   nullify_out  the instruction at pc_front is nullified
//   in_delay     pc_front holds the delay slot of a taken branch
//   ret_addr     link address of the last taken branch-and-link
//   ret_valid    one-cycle pulse, ret_addr may be written to the link register
//   taken_cnt    saturating count of taken branches
//
// State        | meaning
// -------------+-------------------------------------------------------------
// ST_RUN       | sequential flow, front instruction executes normally
// ST_DELAY     | front is the delay slot of a taken branch
// ST_NULL      | front instruction is nullified
// ST_DELAY_NULL| front is a nullified delay slot
// -----------------------------------------------------------------------------
module branch_target_unit #(
   parameter int              PC_W     = 8,
   parameter int              OFF_W    = 21,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [PC_W-1:0]  redirect_pc,
   input  logic             br_valid,
   input  logic [OFF_W-1:0] offset_in,
   input  logic             cond_eval,
   input  logic             bl,
   input  logic             n_bit,
   output logic [PC_W-1:0]  pc_front,
   output logic [PC_W-1:0]  pc_back,
   output logic             nullify_out,
   output logic             in_delay,
   output logic [PC_W-1:0]  ret_addr,
   output logic             ret_valid,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_DELAY      = 2'b01,
      ST_NULL       = 2'b10,
      ST_DELAY_NULL = 2'b11
   } state_t;

   localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);
   localparam logic [PC_W-1:0]  PC_LINK = PC_W'(8);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_front_q, pc_front_d;
   logic [PC_W-1:0]  pc_back_q, pc_back_d;
   logic [PC_W-1:0]  ret_addr_q, ret_addr_d;
   logic             ret_valid_q, ret_valid_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

   logic             null_q;
   logic             off_neg;
   logic [PC_W-1:0]  off_words;
   logic [PC_W-1:0]  link_addr;
   logic [PC_W-1:0]  target_addr;
   logic             br_accept;
   logic             br_taken;
   logic             set_null;

   // Only the low offset bits that survive the modulo-2^PC_W target sum and the
   // sign bit matter; the middle bits are sign-extension copies.
   logic             unused_offset_bits;
   assign unused_offset_bits = ^offset_in[OFF_W-2:PC_W-2];

   assign null_q      = (state_q == ST_NULL) || (state_q == ST_DELAY_NULL);
   assign off_neg     = offset_in[OFF_W-1];
   assign off_words   = {offset_in[PC_W-3:0], 2'b00};
   assign link_addr   = pc_front_q + PC_LINK;
   assign target_addr = link_addr + off_words;

   // A nullified front instruction cannot branch, whatever br_valid says.
   assign br_accept = br_valid && !null_q;
   assign br_taken  = br_accept && cond_eval;

   // Nullify the next instruction: always for branch-and-link, otherwise for a
   // taken forward branch or a not-taken backward branch.
   assign set_null = br_accept && n_bit &&
                     (bl || (cond_eval ? !off_neg : off_neg));

   always_comb begin
      state_d     = state_q;
      pc_front_d  = pc_front_q;
      pc_back_d   = pc_back_q;
      ret_addr_d  = ret_addr_q;
      taken_cnt_d = taken_cnt_q;
      // ret_valid is a pulse: it drops on the edge after it was raised, even if
      // that edge is stalled, so the link register is written only once.
      ret_valid_d = 1'b0;

      if (redirect) begin
         pc_front_d = redirect_pc;
         pc_back_d  = redirect_pc + PC_STEP;
         state_d    = ST_RUN;
      end else if (!stall) begin
         pc_front_d = pc_back_q;
         if (br_taken) begin
            pc_back_d = target_addr;
            if (taken_cnt_q != CNT_MAX) begin
               taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
            if (bl) begin
               ret_addr_d  = link_addr;
               ret_valid_d = 1'b1;
            end
         end else begin
            pc_back_d = pc_back_q + PC_STEP;
         end

         case ({set_null, br_taken})
            2'b00:   state_d = ST_RUN;
            2'b01:   state_d = ST_DELAY;
            2'b10:   state_d = ST_NULL;
            default: state_d = ST_DELAY_NULL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pc_front_q  <= RESET_PC;
         pc_back_q   <= RESET_PC + PC_STEP;
         ret_addr_q  <= '0;
         ret_valid_q <= 1'b0;
         taken_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_front_q  <= pc_front_d;
         pc_back_q   <= pc_back_d;
         ret_addr_q  <= ret_addr_d;
         ret_valid_q <= ret_valid_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign pc_front    = pc_front_q;
   assign pc_back     = pc_back_q;
   assign nullify_out = null_q;
   assign in_delay    = (state_q == ST_DELAY) || (state_q == ST_DELAY_NULL);
   assign ret_addr    = ret_addr_q;
   assign ret_valid   = ret_valid_q;
   assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_target_unit
//
// Directed scenarios for the documented cases followed by a randomized run
// compared every cycle against an arithmetic model of the address queue.
// -----------------------------------------------------------------------------
module tb_branch_target_unit;

   localparam int PC_W  = 8;
   localparam int OFF_W = 21;
   localparam int CNT_W = 8;
   localparam int PC_M  = (1 << PC_W) - 1;
   localparam int C_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             stall;
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;
   logic             br_valid;
   logic [OFF_W-1:0] offset_in;
   logic             cond_eval;
   logic             bl;
   logic             n_bit;
   logic [PC_W-1:0]  pc_front;
   logic [PC_W-1:0]  pc_back;
   logic             nullify_out;
   logic             in_delay;
   logic [PC_W-1:0]  ret_addr;
   logic             ret_valid;
   logic [CNT_W-1:0] taken_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_front, m_back, m_null, m_delay, m_ret, m_rv, m_cnt;
   int cur_off, cur_rpc;

   branch_target_unit #(
      .PC_W    (PC_W),
      .OFF_W   (OFF_W),
      .RESET_PC(8'h00),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .br_valid   (br_valid),
      .offset_in  (offset_in),
      .cond_eval  (cond_eval),
      .bl         (bl),
      .n_bit      (n_bit),
      .pc_front   (pc_front),
      .pc_back    (pc_back),
      .nullify_out(nullify_out),
      .in_delay   (in_delay),
      .ret_addr   (ret_addr),
      .ret_valid  (ret_valid),
      .taken_cnt  (taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s, input logic r, input int rpc, input logic bv,
                         input int off, input logic c, input logic l, input logic n);
      stall       = s;
      redirect    = r;
      cur_rpc     = rpc;
      redirect_pc = PC_W'(rpc);
      br_valid    = bv;
      cur_off     = off;
      offset_in   = OFF_W'(off);
      cond_eval   = c;
      bl          = l;
      n_bit       = n;
   endtask

   task automatic model_reset();
      m_front = 0;
      m_back  = 4;
      m_null  = 0;
      m_delay = 0;
      m_ret   = 0;
      m_rv    = 0;
      m_cnt   = 0;
   endtask

   // One clock edge of the queue, from the rules: redirect first, then stall,
   // then a normal advance with or without an accepted branch.
   task automatic model_edge();
      int acc, tk, nf, tgt, link;
      if (redirect) begin
         m_front = cur_rpc & PC_M;
         m_back  = (cur_rpc + 4) & PC_M;
         m_null  = 0;
         m_delay = 0;
         m_rv    = 0;
      end else if (stall) begin
         m_rv = 0;
      end else begin
         acc  = (br_valid && m_null == 0) ? 1 : 0;
         tk   = (acc == 1 && cond_eval) ? 1 : 0;
         nf   = (acc == 1 && n_bit &&
                 (bl || (cond_eval ? (cur_off >= 0) : (cur_off < 0)))) ? 1 : 0;
         link = (m_front + 8) & PC_M;
         tgt  = (m_front + 8 + cur_off * 4) & PC_M;
         m_rv = 0;
         if (tk == 1) begin
            m_front = m_back;
            m_back  = tgt;
            if (m_cnt < C_MAX) m_cnt++;
            if (bl) begin
               m_ret = link;
               m_rv  = 1;
            end
         end else begin
            m_front = m_back;
            m_back  = (m_back + 4) & PC_M;
         end
         m_delay = tk;
         m_null  = nf;
      end
   endtask

   task automatic check_model();
      check("front",     32'(pc_front),    32'(m_front));
      check("back",      32'(pc_back),     32'(m_back));
      check("nullify",   32'(nullify_out), 32'(m_null));
      check("in_delay",  32'(in_delay),    32'(m_delay));
      check("ret_addr",  32'(ret_addr),    32'(m_ret));
      check("ret_valid", 32'(ret_valid),   32'(m_rv));
      check("taken_cnt", 32'(taken_cnt),   32'(m_cnt));
   endtask

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      check("rst_front",   32'(pc_front),    32'h00);
      check("rst_back",    32'(pc_back),     32'h04);
      check("rst_null",    32'(nullify_out), 32'h0);
      check("rst_delay",   32'(in_delay),    32'h0);
      check("rst_retv",    32'(ret_valid),   32'h0);
      check("rst_reta",    32'(ret_addr),    32'h0);
      check("rst_cnt",     32'(taken_cnt),   32'h0);
      @(negedge clk);
      reset = 1'b0;

      // sequential advances
      step(); check("seq1_front", 32'(pc_front), 32'h04); check("seq1_back", 32'(pc_back), 32'h08);
      step(); check("seq2_front", 32'(pc_front), 32'h08); check("seq2_back", 32'(pc_back), 32'h0C);
      step(); check("seq3_front", 32'(pc_front), 32'h0C); check("seq3_back", 32'(pc_back), 32'h10);

      // branch-and-link taken from 0x10
      set_in(0, 1, 8'h10, 0, 0, 0, 0, 0);
      step(); check("redir_front", 32'(pc_front), 32'h10); check("redir_back", 32'(pc_back), 32'h14);
      set_in(0, 0, 0, 1, 3, 1, 1, 0);
      step();
      check("bl_front", 32'(pc_front), 32'h14);
      check("bl_back",  32'(pc_back),  32'h24);
      check("bl_reta",  32'(ret_addr), 32'h18);
      check("bl_retv",  32'(ret_valid), 32'h1);
      check("bl_cnt",   32'(taken_cnt), 32'h1);
      check("bl_delay", 32'(in_delay),  32'h1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("bl_retv_drop", 32'(ret_valid), 32'h0);
      check("bl_reta_hold", 32'(ret_addr),  32'h18);
      check("bl_delay_clr", 32'(in_delay),  32'h0);
      check("bl_next_back", 32'(pc_back),   32'h28);

      // taken forward branch with n_bit: next instruction nullified, its branch ignored
      set_in(0, 0, 0, 1, 2, 1, 0, 1);
      step();
      check("nt_front", 32'(pc_front),    32'h28);
      check("nt_back",  32'(pc_back),     32'h34);
      check("nt_null",  32'(nullify_out), 32'h1);
      step();
      check("ign_front", 32'(pc_front),    32'h34);
      check("ign_back",  32'(pc_back),     32'h38);
      check("ign_null",  32'(nullify_out), 32'h0);
      check("ign_cnt",   32'(taken_cnt),   32'h2);

      // not-taken backward branch nullifies, forward does not
      set_in(0, 0, 0, 1, -1, 0, 0, 1);
      step();
      check("nb_front", 32'(pc_front),    32'h38);
      check("nb_back",  32'(pc_back),     32'h3C);
      check("nb_null",  32'(nullify_out), 32'h1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("nb_clear", 32'(nullify_out), 32'h0);
      set_in(0, 0, 0, 1, 1, 0, 0, 1);
      step();
      check("nf_back", 32'(pc_back),     32'h44);
      check("nf_null", 32'(nullify_out), 32'h0);

      // stalled taken branch, then redirect under stall, then wrap
      set_in(1, 0, 0, 1, 4, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_front", 32'(pc_front),  32'h40);
         check("stall_back",  32'(pc_back),   32'h44);
         check("stall_delay", 32'(in_delay),  32'h0);
         check("stall_cnt",   32'(taken_cnt), 32'h2);
      end
      set_in(1, 1, 8'hF8, 1, 4, 1, 1, 0);
      step();
      check("rds_front", 32'(pc_front),  32'hF8);
      check("rds_back",  32'(pc_back),   32'hFC);
      check("rds_cnt",   32'(taken_cnt), 32'h2);
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      check("wrap_front", 32'(pc_front), 32'hFC);
      check("wrap_back",  32'(pc_back),  32'h00);

      // counter saturation
      set_in(0, 0, 0, 1, 0, 1, 0, 0);
      for (int i = 0; i < 253; i++) step();
      check("sat_reach", 32'(taken_cnt), 32'd255);
      step();
      check("sat_hold", 32'(taken_cnt), 32'd255);

      // asynchronous reset between edges
      #2;
      reset = 1'b1;
      #1;
      check("arst_front", 32'(pc_front),    32'h00);
      check("arst_back",  32'(pc_back),     32'h04);
      check("arst_null",  32'(nullify_out), 32'h0);
      check("arst_delay", 32'(in_delay),    32'h0);
      check("arst_cnt",   32'(taken_cnt),   32'h0);
      check("arst_reta",  32'(ret_addr),    32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         int off;
         if ($urandom_range(0, 1) == 0) off = int'($urandom_range(0, 64)) - 32;
         else                           off = int'($urandom_range(0, 2097151)) - 1048576;
         set_in($urandom_range(0, 4) == 0,
                $urandom_range(0, 31) == 0,
                int'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1,
                off,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1;
            #1;
            model_reset();
            check_model();
            reset = 1'b0;
            #1;
         end else begin
            step();
            model_edge();
            check_model();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_target_unit.md
BRANCH_TARGET_UNIT -- requirements
Module: branch_target_unit

Interface
REQ-001 Parameter PC_W, default 8: width of PC front/back queue and all address outputs.
REQ-002 Parameter OFF_W, default 21: width of the sign-extended branch offset input.
REQ-003 Parameter RESET_PC, default 0: value loaded into pc_front at reset.
REQ-004 Parameter CNT_W, default 8: width of the taken-branch counter.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port reset, input, 1: asynchronous active-high reset.
REQ-008 Port stall, input, 1: freezes all state when high.
REQ-009 Port redirect, input, 1: load redirect_pc into the queue (exception or restart).
REQ-010 Port redirect_pc, input, PC_W: redirect target address.
REQ-011 Port br_valid, input, 1: the instruction at pc_front is a branch.
REQ-012 Port offset_in, input, OFF_W: sign-extended word offset.
REQ-013 Port cond_eval, input, 1: branch condition true (taken).
REQ-014 Port bl, input, 1: branch-and-link.
REQ-015 Port n_bit, input, 1: nullify bit of the branch.
REQ-016 Port pc_front, output, PC_W: IAOQ front.
REQ-017 Port pc_back, output, PC_W: IAOQ back.
REQ-018 Port nullify_out, output, 1: the instruction at pc_front is nullified.
REQ-019 Port in_delay, output, 1: pc_front holds the delay slot of a taken branch.
REQ-020 Port ret_addr, output, PC_W: link address.
REQ-021 Port ret_valid, output, 1: one-cycle pulse; ret_addr is valid to write GR[t].
REQ-022 Port taken_cnt, output, CNT_W: saturating count of taken branches.

Function
REQ-023 Sampling: an "advance" occurs on a rising clk edge with stall=0; all registers hold while stall=1.
REQ-024 Arithmetic: target = pc_front + 8 + (offset_in[PC_W-3:0] << 2), computed modulo 2^PC_W; link = pc_front + 8 mod 2^PC_W.
REQ-025 Sequential advance (no branch, no redirect): pc_front <= pc_back; pc_back <= pc_back + 4 (wraps).
REQ-026 A branch is accepted only when br_valid=1 and nullify_out=0; if nullify_out=1, br_valid is ignored and the advance is sequential.
REQ-027 Taken branch (accepted, cond_eval=1): pc_front <= pc_back (delay slot); pc_back <= target; in_delay <= 1; taken_cnt increments, saturating at 2^CNT_W-1.
REQ-028 Not-taken branch: sequential advance; in_delay <= 0.
REQ-029 Nullify rule for an accepted branch with n_bit=1:
  - bl=1: the delay slot is nullified.
  - bl=0: the delay slot is nullified if taken with offset_in >= 0, or if not taken with offset_in < 0.
  - In these cases nullify_out <= 1 for the next instruction; otherwise nullify_out <= 0.
REQ-030 nullify_out lasts exactly one advance; it clears on the following advance unless a new nullification is set.
REQ-031 Link: an accepted taken branch with bl=1 registers ret_addr <= link and pulses ret_valid for exactly one cycle. ret_addr holds its value afterwards.
REQ-032 A taken branch while in_delay=1 (branch in delay slot) is accepted per REQ-027; pc_front <= pc_back, the previous target.
REQ-033 State machine, states:
  - RUN: default.
  - DELAY: in_delay=1.
  - NULL: nullify_out=1.
  - Transitions occur only on an advance, per REQ-027 to REQ-030.
  - DELAY and NULL may be active together.
REQ-034 Redirect has priority over any branch:
  - pc_front <= redirect_pc; pc_back <= redirect_pc + 4.
  - in_delay, nullify_out and ret_valid <= 0.
  - taken_cnt is unchanged.
  - redirect is honoured even when stall=1.
REQ-035 Latency: every output is registered; a branch decided in cycle N is visible after edge N+1. There is no combinational path from inputs to outputs.

Reset
REQ-036 Reset values:
  - pc_front = RESET_PC; pc_back = RESET_PC + 4.
  - nullify_out = 0; in_delay = 0; ret_valid = 0.
  - ret_addr = 0; taken_cnt = 0; state RUN.
REQ-037 Reset asserted mid-branch or mid-stall discards all pending state immediately, without waiting for a clock edge.

Verification
REQ-038 Reset release, PC_W=8, no branches, 3 advances -> pc_front 0→4→8→12, pc_back 4→8→12→16.
REQ-039 pc_front=0x10, pc_back=0x14, br_valid=1, cond_eval=1, bl=1, offset=3 -> next pc_front=0x14, pc_back=0x24, ret_addr=0x18, ret_valid high for 1 cycle, taken_cnt=1.
REQ-040 Taken forward branch with n_bit=1, offset=2 -> nullify_out=1 for one advance; a br_valid presented during that cycle is ignored.
REQ-041 Not-taken branch, offset=-1, n_bit=1 -> sequential advance and nullify_out=1; the same branch with offset=+1 -> nullify_out=0.
REQ-042 Stall held 3 cycles during a taken branch, then redirect=1 with redirect_pc=0xF8 -> outputs frozen while stalled; after redirect pc_front=0xF8 and pc_back=0xFC; next advance gives pc_back=0x00 (wrap).
REQ-043 taken_cnt at 255 (CNT_W=8) plus one more taken branch -> taken_cnt stays 255; async reset mid-cycle -> all outputs at reset values before the next edge.
